// File: rtl/inj_trig_sequencer_if.sv
// Bus-side signal bundle of the injection/trigger sequencer.
// The master side (configuration, command encoder and FIFO status) drives the
// request and status inputs; the sequencer (slave) drives the pulses and flags.
interface inj_trig_sequencer_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 START;
    logic                 ABORT;
    logic [CNT_WIDTH-1:0] CFG_REPEAT;
    logic [CNT_WIDTH-1:0] CFG_TRIG_DELAY;
    logic [CNT_WIDTH-1:0] CFG_GAP;
    logic [CNT_WIDTH-1:0] CFG_TIMEOUT;
    logic                 CMD_BUSY;
    logic                 FIFO_NEAR_FULL;

    logic                 INJ_START;
    logic                 TRIG_START;
    logic                 BUSY;
    logic                 DONE;
    logic                 TIMEOUT_ERR;
    logic [CNT_WIDTH-1:0] INJ_COUNT;

    modport master (
        output START, ABORT, CFG_REPEAT, CFG_TRIG_DELAY, CFG_GAP, CFG_TIMEOUT,
               CMD_BUSY, FIFO_NEAR_FULL,
        input  INJ_START, TRIG_START, BUSY, DONE, TIMEOUT_ERR, INJ_COUNT
    );

    modport slave (
        input  START, ABORT, CFG_REPEAT, CFG_TRIG_DELAY, CFG_GAP, CFG_TIMEOUT,
               CMD_BUSY, FIFO_NEAR_FULL,
        output INJ_START, TRIG_START, BUSY, DONE, TIMEOUT_ERR, INJ_COUNT
    );
endinterface

// File: rtl/inj_trig_sequencer.sv
// Injection scan sequencer: pulses the injection pulser, waits a programmable
// delay, pulses the command encoder start, waits for the encoder to finish,
// idles for a gap and repeats. Throttles between injections while the
// downstream FIFOs report near-full. Single clock domain (BUS_CLK).
module inj_trig_sequencer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST,
    inj_trig_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INJ,
        S_TRIG_DLY,
        S_TRIG,
        S_CMD_WAIT,
        S_GAP,
        S_THROTTLE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    state_t               state_q;

    // Configuration captured at START so a run is immune to later CFG changes.
    logic [CNT_WIDTH-1:0] rep_q;
    logic [CNT_WIDTH-1:0] dly_q;
    logic [CNT_WIDTH-1:0] gap_q;
    logic [CNT_WIDTH-1:0] tmo_q;

    logic [CNT_WIDTH-1:0] dly_cnt_q;
    logic [CNT_WIDTH-1:0] gap_cnt_q;
    logic [CNT_WIDTH-1:0] tmo_cnt_q;
    logic [CNT_WIDTH-1:0] inj_count_q;
    logic                 seen_busy_q;

    logic                 inj_start_q;
    logic                 trig_start_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 timeout_err_q;

    logic [CNT_WIDTH-1:0] inj_count_d;
    logic [CNT_WIDTH-1:0] tmo_cnt_d;
    logic                 run_done;

    assign inj_count_d = inj_count_q + ONE;
    assign tmo_cnt_d   = tmo_cnt_q + ONE;
    // A finite run ends once the number of issued injections matches the target.
    assign run_done    = (rep_q != '0) && (inj_count_q == rep_q);

    // Sequencer FSM with registered pulse/flag outputs; ABORT overrides every state.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_q       <= S_IDLE;
            rep_q         <= '0;
            dly_q         <= '0;
            gap_q         <= '0;
            tmo_q         <= '0;
            dly_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            inj_count_q   <= '0;
            seen_busy_q   <= 1'b0;
            inj_start_q   <= 1'b0;
            trig_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees the
            // pre-edge register values and the pulse defaults below are simply
            // overridden by whichever branch raises a pulse.
            inj_start_q  <= 1'b0;
            trig_start_q <= 1'b0;
            done_q       <= 1'b0;

            if (bus.ABORT) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (bus.START) begin
                            rep_q         <= bus.CFG_REPEAT;
                            dly_q         <= bus.CFG_TRIG_DELAY;
                            gap_q         <= bus.CFG_GAP;
                            tmo_q         <= bus.CFG_TIMEOUT;
                            timeout_err_q <= 1'b0;
                            // Count restarts at zero and the first injection is issued now.
                            inj_count_q   <= ONE;
                            inj_start_q   <= 1'b1;
                            busy_q        <= 1'b1;
                            state_q       <= S_INJ;
                        end
                    end

                    S_INJ: begin
                        // A zero delay skips the delay state so TRIG follows INJ directly.
                        if (dly_q == '0) begin
                            trig_start_q <= 1'b1;
                            state_q      <= S_TRIG;
                        end else begin
                            dly_cnt_q <= dly_q - ONE;
                            state_q   <= S_TRIG_DLY;
                        end
                    end

                    S_TRIG_DLY: begin
                        if (dly_cnt_q == '0) begin
                            trig_start_q <= 1'b1;
                            state_q      <= S_TRIG;
                        end else begin
                            dly_cnt_q <= dly_cnt_q - ONE;
                        end
                    end

                    S_TRIG: begin
                        seen_busy_q <= 1'b0;
                        tmo_cnt_q   <= '0;
                        state_q     <= S_CMD_WAIT;
                    end

                    S_CMD_WAIT: begin
                        // The encoder must be seen busy first, so a slow busy
                        // assertion is not mistaken for completion.
                        if (seen_busy_q && !bus.CMD_BUSY) begin
                            gap_cnt_q <= gap_q;
                            state_q   <= S_GAP;
                        end else if ((tmo_q != '0) && (tmo_cnt_d == tmo_q)) begin
                            timeout_err_q <= 1'b1;
                            busy_q        <= 1'b0;
                            state_q       <= S_IDLE;
                        end else begin
                            seen_busy_q <= seen_busy_q | bus.CMD_BUSY;
                            tmo_cnt_q   <= tmo_cnt_d;
                        end
                    end

                    S_GAP: begin
                        // Gap of 0 or 1 both give a single cycle here.
                        if (gap_cnt_q > ONE) begin
                            gap_cnt_q <= gap_cnt_q - ONE;
                        end else if (run_done) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else if (bus.FIFO_NEAR_FULL) begin
                            state_q <= S_THROTTLE;
                        end else begin
                            inj_count_q <= inj_count_d;
                            inj_start_q <= 1'b1;
                            state_q     <= S_INJ;
                        end
                    end

                    S_THROTTLE: begin
                        if (!bus.FIFO_NEAR_FULL) begin
                            inj_count_q <= inj_count_d;
                            inj_start_q <= 1'b1;
                            state_q     <= S_INJ;
                        end
                    end

                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.INJ_START   = inj_start_q;
    assign bus.TRIG_START  = trig_start_q;
    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
    assign bus.TIMEOUT_ERR = timeout_err_q;
    assign bus.INJ_COUNT   = inj_count_q;

endmodule

// File: tb/tb_inj_trig_sequencer.sv
// Testbench for inj_trig_sequencer. Each scenario is planned up front: a
// timeline model derives, from the sequencing rules, the cycle of every
// INJ/TRIG pulse, the command-busy response, gap/throttle exits, timeouts,
// DONE and aborts; the DUT outputs are then compared cycle by cycle.
module tb_inj_trig_sequencer;

    localparam int W    = 16;
    localparam int MAXC = 1000;

    logic BUS_CLK = 1'b0;
    logic BUS_RST;

    always #5 BUS_CLK = ~BUS_CLK;

    inj_trig_sequencer_if #(.CNT_WIDTH(W)) bus ();

    inj_trig_sequencer #(.CNT_WIDTH(W)) dut (
        .BUS_CLK (BUS_CLK),
        .BUS_RST (BUS_RST),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus per cycle (inputs present during cycle n) and expected outputs
    // (register values during cycle n).
    logic         st_start [MAXC];
    logic         st_abort [MAXC];
    logic         st_fifo  [MAXC];
    logic         st_busy  [MAXC];
    logic [W-1:0] st_rep   [MAXC];
    logic [W-1:0] st_dly   [MAXC];
    logic [W-1:0] st_gap   [MAXC];
    logic [W-1:0] st_tmo   [MAXC];
    logic         ex_inj   [MAXC];
    logic         ex_trig  [MAXC];
    logic         ex_busy  [MAXC];
    logic         ex_done  [MAXC];
    logic         ex_err   [MAXC];
    logic [W-1:0] ex_cnt   [MAXC];
    int           inj_at[$];
    logic [W-1:0] held_cnt;
    logic         held_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int urange(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    function automatic logic [31:0] obs();
        return {11'd0, bus.INJ_START, bus.TRIG_START, bus.BUSY, bus.DONE,
                bus.TIMEOUT_ERR, bus.INJ_COUNT};
    endfunction

    function automatic logic [31:0] expv(input int n);
        return {11'd0, ex_inj[n], ex_trig[n], ex_busy[n], ex_done[n], ex_err[n], ex_cnt[n]};
    endfunction

    task automatic drive_idle();
        bus.START          = 1'b0;
        bus.ABORT          = 1'b0;
        bus.CMD_BUSY       = 1'b0;
        bus.FIFO_NEAR_FULL = 1'b0;
        bus.CFG_REPEAT     = '0;
        bus.CFG_TRIG_DELAY = '0;
        bus.CFG_GAP        = '0;
        bus.CFG_TIMEOUT    = '0;
    endtask

    task automatic clear_scenario();
        inj_at.delete();
        for (int n = 0; n < MAXC; n++) begin
            st_start[n] = 1'b0;
            st_abort[n] = 1'b0;
            st_fifo[n]  = 1'b0;
            st_busy[n]  = 1'b0;
            st_rep[n]   = W'($urandom);
            st_dly[n]   = W'($urandom);
            st_gap[n]   = W'($urandom);
            st_tmo[n]   = W'($urandom);
            ex_inj[n]   = 1'b0;
            ex_trig[n]  = 1'b0;
            ex_done[n]  = 1'b0;
            ex_busy[n]  = 1'b0;
            ex_cnt[n]   = held_cnt;
            ex_err[n]   = held_err;
        end
    endtask

    task automatic fill(input int from, input int upto, input logic b,
                        input logic [W-1:0] c, input logic e);
        for (int n = from; n < upto && n < MAXC; n++) begin
            if (n >= 0) begin
                ex_busy[n] = b;
                ex_cnt[n]  = c;
                ex_err[n]  = e;
            end
        end
    endtask

    // Timeline of one run started at cycle s. pa/pl fix the busy response
    // (busy rises pa cycles after TRIG_START, lasts pl cycles); -1 = random.
    task automatic model_run(input int s, input int rep, input int dly, input int gap,
                             input int tmo, input int pa, input int pl, input int limit,
                             output int run_end);
        int t, p, c, e, d, f, a, l, g;
        logic [W-1:0] cnt;
        logic timed_out;
        st_start[s] = 1'b1;
        st_rep[s]   = W'(rep);
        st_dly[s]   = W'(dly);
        st_gap[s]   = W'(gap);
        st_tmo[s]   = W'(tmo);
        cnt = '0;
        t = s + 1;
        p = s + 1;
        run_end = -1;
        timed_out = 1'b0;
        while (run_end < 0) begin
            if (t >= limit) begin
                fill(p, limit, 1'b1, cnt, 1'b0);
                run_end = limit;
            end else begin
                fill(p, t, 1'b1, cnt, 1'b0);
                cnt = cnt + 1'b1;
                ex_inj[t] = 1'b1;
                inj_at.push_back(t);
                c = t + dly + 1;
                if (c < MAXC) ex_trig[c] = 1'b1;
                a = (pa < 0) ? urange(1, 4) : pa;
                if (pl >= 0)       l = pl;
                else if (tmo == 0) l = urange(1, 12);
                else               l = urange(0, 12);
                for (int k = 0; k < l; k++)
                    if (c + a + k < MAXC) st_busy[c + a + k] = 1'b1;
                // Completion: first cycle after the busy burst, once busy was seen.
                e = (l == 0) ? 32'h3fff_ffff : c + a + l;
                if (tmo != 0 && c + tmo < e) begin
                    fill(t, c + tmo + 1, 1'b1, cnt, 1'b0);
                    run_end = c + tmo + 1;
                    timed_out = 1'b1;
                end else begin
                    g = (gap == 0) ? 1 : gap;
                    d = e + g;
                    fill(t, d + 1, 1'b1, cnt, 1'b0);
                    if (rep != 0 && cnt == W'(rep)) begin
                        if (d + 1 < MAXC) ex_done[d + 1] = 1'b1;
                        run_end = d + 1;
                    end else begin
                        p = d + 1;
                        f = d;
                        if (d < MAXC && st_fifo[d]) begin
                            f = d + 1;
                            while (f < MAXC - 1 && st_fifo[f]) f++;
                        end
                        t = f + 1;
                    end
                end
            end
        end
        held_cnt = cnt;
        held_err = timed_out;
        fill(run_end, MAXC, 1'b0, held_cnt, held_err);
    endtask

    // ABORT during cycle ab: from the next cycle on the sequencer is idle with
    // count and error flag frozen at their cycle-ab values.
    task automatic apply_abort(input int ab);
        st_abort[ab] = 1'b1;
        for (int n = ab + 1; n < MAXC; n++) begin
            ex_inj[n]  = 1'b0;
            ex_trig[n] = 1'b0;
            ex_done[n] = 1'b0;
            ex_busy[n] = 1'b0;
            ex_cnt[n]  = ex_cnt[ab];
            ex_err[n]  = ex_err[ab];
        end
        held_cnt = ex_cnt[ab];
        held_err = ex_err[ab];
        while (inj_at.size() > 0 && inj_at[$] > ab) void'(inj_at.pop_back());
    endtask

    // Called on a falling edge; checks outputs and drives inputs cycle by cycle.
    task automatic run_scenario(input string name, input int len);
        int n_inj;
        n_inj = 0;
        for (int n = 0; n < len; n++) begin
            check($sformatf("%s cyc%0d {inj,trig,busy,done,err,cnt}", name, n), obs(), expv(n));
            if (bus.INJ_START) n_inj++;
            bus.START          = st_start[n];
            bus.ABORT          = st_abort[n];
            bus.CMD_BUSY       = st_busy[n];
            bus.FIFO_NEAR_FULL = st_fifo[n];
            bus.CFG_REPEAT     = st_rep[n];
            bus.CFG_TRIG_DELAY = st_dly[n];
            bus.CFG_GAP        = st_gap[n];
            bus.CFG_TIMEOUT    = st_tmo[n];
            @(negedge BUS_CLK);
        end
        check($sformatf("%s inj_pulses", name), 32'(n_inj), 32'(inj_at.size()));
        drive_idle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int re, ab, eb, len, s, rep, dly, gap, tmo, bl;
        logic found;

        BUS_RST = 1'b1;
        drive_idle();
        held_cnt = '0;
        held_err = 1'b0;
        repeat (3) @(negedge BUS_CLK);
        check("reset_outputs", obs(), 32'd0);
        BUS_RST = 1'b0;
        @(negedge BUS_CLK);
        check("reset_idle", obs(), 32'd0);

        // Basic run: 3 injections, delay 4, gap 2, busy 10 cycles from TRIG+2.
        clear_scenario();
        model_run(2, 3, 4, 2, 0, 2, 10, MAXC - 20, re);
        run_scenario("basic", re + 5);

        // Timeout: encoder never busy, timeout 20.
        clear_scenario();
        model_run(2, 3, 4, 2, 20, 1, 0, MAXC - 20, re);
        run_scenario("timeout", re + 5);

        // Throttle (its START also clears the sticky timeout flag).
        clear_scenario();
        for (int n = 5; n <= 54; n++) st_fifo[n] = 1'b1;
        st_fifo[58] = 1'b1;
        model_run(2, 2, 4, 2, 0, 2, 10, MAXC - 20, re);
        run_scenario("throttle", re + 5);

        // Abort during the 4th TRIG_DLY of an endless run, then START+ABORT in IDLE.
        clear_scenario();
        model_run(2, 0, 6, 1, 0, -1, -1, 900, re);
        ab = inj_at[3] + 3;
        apply_abort(ab);
        st_start[ab + 4] = 1'b1;
        st_abort[ab + 4] = 1'b1;
        run_scenario("abort", ab + 10);
        check("abort_count", 32'(bus.INJ_COUNT), 32'd4);

        // Zero delay and gap, CFG changing every cycle, extra START while busy.
        clear_scenario();
        model_run(2, 4, 0, 0, 0, -1, -1, MAXC - 20, re);
        st_start[5] = 1'b1;
        run_scenario("shadow", re + 5);

        // Reset while INJ_START is high.
        bus.CFG_REPEAT     = W'(3);
        bus.CFG_TRIG_DELAY = W'(4);
        bus.CFG_GAP        = W'(2);
        bus.START          = 1'b1;
        @(negedge BUS_CLK);
        bus.START = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.INJ_START) found = 1'b1;
            else @(negedge BUS_CLK);
        end
        check("rst_inj_seen", 32'(found), 32'd1);
        #2 BUS_RST = 1'b1;
        #1 check("rst_async_outputs", obs(), 32'd0);
        @(negedge BUS_CLK);
        BUS_RST = 1'b0;
        drive_idle();
        @(negedge BUS_CLK);
        check("rst_release_idle", obs(), 32'd0);
        held_cnt = '0;
        held_err = 1'b0;

        // Randomized runs.
        for (int it = 0; it < 30; it++) begin
            clear_scenario();
            s   = urange(1, 4);
            rep = urange(0, 5);
            dly = urange(0, 12);
            gap = urange(0, 6);
            tmo = (urange(0, 2) == 0) ? urange(8, 30) : 0;
            for (int n = s + 2; n < 700; n++) begin
                if (urange(0, 19) == 0) begin
                    bl = urange(1, 15);
                    for (int k = 0; k < bl && n + k < 700; k++) st_fifo[n + k] = 1'b1;
                end
            end
            model_run(s, rep, dly, gap, tmo, -1, -1, (rep == 0) ? 600 : MAXC - 20, re);
            ab = -1;
            if (rep == 0 || urange(0, 2) == 0) begin
                ab = urange(s + 1, (rep == 0) ? 580 : re + 2);
                apply_abort(ab);
            end
            eb = (ab >= 0 && ab < re - 1) ? ab : re - 1;
            if (eb >= s + 1) st_start[urange(s + 1, eb)] = 1'b1;
            len = ((ab >= 0 && ab < re) ? ab : re) + 6;
            run_scenario($sformatf("rand%0d", it), len);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/inj_trig_sequencer.md
Name: inj_trig_sequencer

Overview:
- Automates injection scans: fires the injection pulser, waits a programmable delay, fires the trigger-command start, waits for the command encoder to finish, then repeats N times.
- Throttles on FIFO_NEAR_FULL so arbiter input FIFOs do not overflow.
- Sits between the GPIO/bus configuration and the EXT_START inputs of the injection pulser and the command encoder.
- Runs entirely in the BUS_CLK domain.

Parameters:
- CNT_WIDTH, 16, width of the repeat, delay, gap and timeout counters and configuration inputs.

Ports:
- BUS_CLK  in  1  single clock for all logic.
- BUS_RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle start request; honoured only in IDLE.
- ABORT  in  1  stops the sequence at the next clock edge.
- CFG_REPEAT  in  CNT_WIDTH  number of injections; 0 = run until ABORT.
- CFG_TRIG_DELAY  in  CNT_WIDTH  cycles from INJ_START to TRIG_START, minus 1.
- CFG_GAP  in  CNT_WIDTH  idle cycles after command completion.
- CFG_TIMEOUT  in  CNT_WIDTH  maximum cycles spent in CMD_WAIT; 0 = no timeout.
- CMD_BUSY  in  1  command encoder writing flag.
- FIFO_NEAR_FULL  in  1  throttle request.
- INJ_START  out  1  one-cycle pulse to the injection pulser.
- TRIG_START  out  1  one-cycle pulse to the command encoder.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse on normal completion.
- TIMEOUT_ERR  out  1  sticky error flag.
- INJ_COUNT  out  CNT_WIDTH  injections issued in the current run.

Behaviour:
- All outputs are registered. Reset values: state IDLE, every output 0, all counters 0.
- On START in IDLE, CFG_* is latched into shadow registers. Later CFG changes have no effect until the next START.
- States: IDLE, INJ, TRIG_DLY, TRIG, CMD_WAIT, GAP, THROTTLE.
- IDLE -> INJ on START with ABORT low. TIMEOUT_ERR and INJ_COUNT clear on that edge.
- INJ (1 cycle):
  - INJ_START = 1; INJ_COUNT increments, wrapping at 2^CNT_WIDTH.
  - Next state is TRIG_DLY, loaded with the shadow delay.
- TRIG_DLY: counts down. When it reaches 0, go to TRIG.
- TRIG_START timing: asserted exactly CFG_TRIG_DELAY+1 cycles after INJ_START. Delay 0 puts TRIG_START on the cycle after INJ_START.
- TRIG (1 cycle): TRIG_START = 1, then go to CMD_WAIT. The seen_busy flag clears and the timeout counter clears.
- CMD_WAIT:
  - seen_busy sets when CMD_BUSY = 1.
  - Exit to GAP on the first cycle with seen_busy set and CMD_BUSY = 0.
  - If CFG_TIMEOUT != 0 and the timeout counter reaches CFG_TIMEOUT: set TIMEOUT_ERR and go to IDLE. No DONE pulse.
- GAP: counts CFG_GAP cycles (0 = single pass-through cycle). At the end:
  - If CFG_REPEAT != 0 and INJ_COUNT == CFG_REPEAT: DONE = 1 for one cycle, go to IDLE.
  - Else if FIFO_NEAR_FULL: go to THROTTLE.
  - Else: go to INJ.
- THROTTLE: stays while FIFO_NEAR_FULL = 1. Goes to INJ on the first cycle it is low.
- FIFO_NEAR_FULL has no effect in any other state. An injection already started always completes its trigger.
- ABORT, in any state: IDLE on the next edge. No further INJ_START, TRIG_START or DONE. INJ_COUNT and TIMEOUT_ERR are held.
- ABORT and START in the same cycle: ABORT wins.
- START while BUSY is ignored.
- BUS_RST asserted mid-sequence clears everything immediately, asynchronously. Pulses are cut short.
- INJ_START and TRIG_START are never high in the same cycle. Minimum spacing between consecutive INJ_START pulses is 5 cycles.

Test Plan:
- Basic run. Set REPEAT=3, TRIG_DELAY=4, GAP=2, TIMEOUT=0. CMD_BUSY is driven high for 10 cycles starting 2 cycles after each TRIG_START. Required: 3 INJ_START pulses, each TRIG_START exactly 5 cycles after its INJ_START, DONE once, INJ_COUNT=3, BUSY low after DONE.
- Timeout. Set TIMEOUT=20 and hold CMD_BUSY low. Required: one INJ_START and one TRIG_START, TIMEOUT_ERR=1 exactly 20 cycles into CMD_WAIT, return to IDLE, no DONE. A following START clears TIMEOUT_ERR.
- Throttle. Set REPEAT=2 and hold FIFO_NEAR_FULL high through the first GAP for 50 cycles. Required: the second INJ_START occurs exactly 1 cycle after FIFO_NEAR_FULL falls. FIFO_NEAR_FULL pulsed during TRIG_DLY has no effect.
- Abort. Set REPEAT=0 and assert ABORT during TRIG_DLY of the 4th injection. Required: no further TRIG_START, BUSY low next cycle, INJ_COUNT=4, no DONE. START together with ABORT in IDLE does not start a run.
- Config shadowing and edge delays. Set TRIG_DELAY=0 and GAP=0, and change CFG_TRIG_DELAY mid-run. Required: TRIG_START always on the cycle after INJ_START, and a second START while BUSY is ignored.
- Reset mid-sequence. Assert BUS_RST while INJ_START is high. Required: all outputs 0 asynchronously, state IDLE after release.
